dbi_tx_sched: RTL and testbench

//  - Transmit-side DBI burst scheduler: accepts 8-bit write beats from one requester, frames them into

---
 rtl/dbi_tx_sched_pkg.sv | 24 ++
 rtl/dbi_tx_sched_maj9.sv | 19 +
 rtl/dbi_tx_sched.sv | 173 +++++++++++++++++
 tb/tb_dbi_tx_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbi_tx_sched_pkg.sv
// Shared types and widths for the DBI transmit burst scheduler.
// The optional AC (toggle-minimising) mode is compiled in with DBI_AC_EN.
package dbi_tx_sched_pkg;

    localparam int unsigned DQ_W       = 8;
    localparam int unsigned MAJ_N      = 9;
    localparam int unsigned MAJ_THRESH = 5;
    localparam int unsigned MAJ_CNT_W  = 4;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned GAP_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // One beat as presented to the pad stage.
    typedef struct packed {
        logic [DQ_W-1:0] dq;
        logic            dbi;
    } beat_t;

endpackage

// File: rtl/dbi_tx_sched_maj9.sv
// Combinational 9-input majority voter: high when at least MAJ_THRESH inputs are set.
module dbi_tx_sched_maj9
    import dbi_tx_sched_pkg::*;
(
    input  logic [MAJ_N-1:0] vote_in,
    output logic             maj_c
);

    logic [MAJ_CNT_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < MAJ_N; i++) begin
            ones = ones + MAJ_CNT_W'(vote_in[i]);
        end
        maj_c = (ones >= MAJ_CNT_W'(MAJ_THRESH));
    end

endmodule

// File: rtl/dbi_tx_sched.sv
// DBI transmit burst scheduler: frames beats into fixed bursts with a gap and applies DBI inversion.
// Define DBI_AC_EN to build the AC (toggle-minimising) mode and its prev_dq history register.
module dbi_tx_sched
    import dbi_tx_sched_pkg::*;
#(
    parameter int unsigned     BURST_LEN    = 8,
    parameter int unsigned     GAP_CYC      = 2,
    parameter logic [DQ_W-1:0] IDLE_PATTERN = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dbi_en,
    input  logic            dbi_mode,
    input  logic            in_valid,
    input  logic [DQ_W-1:0] in_data,
    output logic            in_ready,
    output logic [DQ_W-1:0] dq_out,
    output logic            dbi_out,
    output logic            dq_oe,
    output logic            dq_valid,
    output logic            burst_last
);

    localparam beat_t IDLE_BEAT = '{dq: IDLE_PATTERN, dbi: 1'b0};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ready_q, ready_d;
    beat_t            out_q, out_d;
    logic             oe_q, oe_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             accept;
    logic [DQ_W-1:0]  vote;
    logic             maj_c;
    logic             invert;
    beat_t            new_beat;

    // Voter input: bits that would be "costly" if sent uninverted.
`ifdef DBI_AC_EN
    logic             mode_q, mode_d;
    logic [DQ_W-1:0]  prev_q, prev_d;
    logic             mode_eff;

    assign mode_eff = (state_q == ST_IDLE) ? dbi_mode : mode_q;
    assign vote     = mode_eff ? (in_data ^ prev_q) : ~in_data;
`else
    logic             unused_mode;

    assign unused_mode = dbi_mode;
    assign vote        = ~in_data;
`endif

    dbi_tx_sched_maj9 u_maj (
        .vote_in ({1'b0, vote}),
        .maj_c   (maj_c)
    );

    assign accept       = in_valid & ready_q;
    assign invert       = dbi_en & maj_c;
    assign new_beat.dq  = invert ? ~in_data : in_data;
    assign new_beat.dbi = invert;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ready_d    = ready_q;
        out_d      = out_q;
        oe_d       = oe_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
`ifdef DBI_AC_EN
        mode_d     = mode_q;
        prev_d     = prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                out_d   = IDLE_BEAT;
                oe_d    = 1'b0;
                if (accept) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = CNT_W'(1);
                    out_d      = new_beat;
                    oe_d       = 1'b1;
                    valid_d    = 1'b1;
`ifdef DBI_AC_EN
                    mode_d     = dbi_mode;
                    prev_d     = new_beat.dq;
`endif
                end
            end
            ST_BURST: begin
                // Bubbles hold the last beat on the bus with dq_oe still asserted.
                if (accept) begin
                    out_d   = new_beat;
                    valid_d = 1'b1;
`ifdef DBI_AC_EN
                    prev_d  = new_beat.dq;
`endif
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d    = ST_GAP;
                        beat_cnt_d = '0;
                        gap_cnt_d  = '0;
                        ready_d    = 1'b0;
                        last_d     = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                out_d   = IDLE_BEAT;
                oe_d    = 1'b0;
                ready_d = 1'b0;
`ifdef DBI_AC_EN
                prev_d  = IDLE_PATTERN;
`endif
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                    ready_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ready_q    <= 1'b0;
            out_q      <= IDLE_BEAT;
            oe_q       <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef DBI_AC_EN
            mode_q     <= 1'b0;
            prev_q     <= IDLE_PATTERN;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ready_q    <= ready_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
`ifdef DBI_AC_EN
            mode_q     <= mode_d;
            prev_q     <= prev_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign dq_out     = out_q.dq;
    assign dbi_out    = out_q.dbi;
    assign dq_oe      = oe_q;
    assign dq_valid   = valid_q;
    assign burst_last = last_q;

endmodule

// File: tb/tb_dbi_tx_sched.sv
// Self-checking bench for dbi_tx_sched: directed literal cases plus randomized traffic against
// a behavioural model of burst framing and the DBI inversion rule.
module tb_dbi_tx_sched;

    localparam int         BL   = 8;
    localparam int         GC   = 2;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dbi_en;
    logic       dbi_mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] dq_out;
    logic       dbi_out;
    logic       dq_oe;
    logic       dq_valid;
    logic       burst_last;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: beats accepted in the current burst and gap cycles still owed.
    logic       m_ready;
    logic [7:0] m_dq;
    logic       m_dbi, m_oe, m_valid, m_last;
    logic [7:0] m_prev;
    logic       m_mode;
    int         beats;
    int         gap_left;

    dbi_tx_sched #(
        .BURST_LEN    (BL),
        .GAP_CYC      (GC),
        .IDLE_PATTERN (IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbi_en     (dbi_en),
        .dbi_mode   (dbi_mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dq_out     (dq_out),
        .dbi_out    (dbi_out),
        .dq_oe      (dq_oe),
        .dq_valid   (dq_valid),
        .burst_last (burst_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_dq     = IDLE;
        m_dbi    = 1'b0;
        m_oe     = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_prev   = IDLE;
        m_mode   = 1'b0;
        beats    = 0;
        gap_left = 0;
    endtask

    task automatic model_emit();
        int cnt;
        cnt = 8 - $countones(in_data);
`ifdef DBI_AC_EN
        if (m_mode) cnt = $countones(in_data ^ m_prev);
`endif
        m_dbi   = dbi_en && (cnt >= 5);
        m_dq    = m_dbi ? ~in_data : in_data;
        m_prev  = m_dq;
        m_oe    = 1'b1;
        m_valid = 1'b1;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic acc;
        acc     = in_valid && m_ready;
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (gap_left > 0) begin
            m_oe   = 1'b0;
            m_dq   = IDLE;
            m_dbi  = 1'b0;
            m_prev = IDLE;
            gap_left--;
            m_ready = (gap_left == 0);
        end else if (beats == 0) begin
            m_ready = 1'b1;
            if (acc) begin
                m_mode = dbi_mode;
                model_emit();
                beats = 1;
            end else begin
                m_oe  = 1'b0;
                m_dq  = IDLE;
                m_dbi = 1'b0;
            end
        end else if (acc) begin
            model_emit();
            beats++;
            if (beats == BL) begin
                beats    = 0;
                gap_left = GC;
                m_ready  = 1'b0;
                m_last   = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("cycle", {in_ready, dq_out, dbi_out, dq_oe, dq_valid, burst_last},
            {m_ready, m_dq, m_dbi, m_oe, m_valid, m_last});
    endtask

    // Called at a falling edge; drives inputs, crosses one rising edge, checks at next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic en, input logic md);
        in_valid = v;
        in_data  = d;
        dbi_en   = en;
        dbi_mode = md;
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("reset_vals", {in_ready, dq_out, dbi_out, dq_oe, dq_valid, burst_last},
            {1'b0, 8'hFF, 4'b0000});
        @(negedge clk);
        check_model();
        rst_n = 1'b1;
    endtask

    int oe_first8;
    int ready_low;
    int last_cnt;
    int last_pos;
    int oe_step11;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        dbi_en   = 1'b0;
        dbi_mode = 1'b0;
        model_reset();
        @(negedge clk);
        check_model();
        chk("reset_state", {in_ready, dq_out, dbi_out, dq_oe, dq_valid, burst_last},
            {1'b0, 8'hFF, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ready_rise", in_ready, 1'b1);

        // DC decisions, dbi_en disable, mid-burst mode toggles
        step(1'b1, 8'h00, 1'b1, 1'b0);
        chk("dc_all_zero", {dq_out, dbi_out, dq_oe, dq_valid}, {8'hFF, 1'b1, 1'b1, 1'b1});
        step(1'b1, 8'h0F, 1'b1, 1'b0);
        chk("dc_tie", {dq_out, dbi_out}, {8'h0F, 1'b0});
        step(1'b1, 8'h00, 1'b0, 1'b1);
        chk("dbi_disabled", {dq_out, dbi_out}, {8'h00, 1'b0});
        for (int i = 4; i <= 8; i++) begin
            step(1'b1, 8'h01, 1'b1, i[0]);
            if (i == 7) chk("not_last_yet", burst_last, 1'b0);
        end
        chk("mode_ignored_last", {dq_out, dbi_out, burst_last}, {8'hFE, 1'b1, 1'b1});

        // Framing with continuous valid
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        oe_first8 = 0;
        ready_low = 0;
        last_cnt  = 0;
        last_pos  = 0;
        oe_step11 = 0;
        for (int s = 1; s <= 12; s++) begin
            step(1'b1, 8'($urandom), 1'($urandom), 1'b0);
            if (s <= 8 && dq_oe) oe_first8++;
            if (!in_ready) ready_low++;
            if (burst_last) begin
                last_cnt++;
                last_pos = s;
            end
            if (s == 11) oe_step11 = int'(dq_oe);
        end
        chk("frame_oe_8", oe_first8, 8);
        chk("frame_last_once", last_cnt, 1);
        chk("frame_last_pos", last_pos, 8);
        chk("frame_gap_len", ready_low, GC);
        chk("frame_restart", oe_step11, 1);

        // Bubbles after beat 3
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 8'hF0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom), 1'b1, 1'b0);
            chk("bubble_hold", {dq_out, dbi_out, dq_oe, dq_valid}, {8'hF3, 1'b0, 1'b1, 1'b0});
        end
        for (int i = 4; i <= 8; i++) step(1'b1, 8'hF0 + 8'(i), 1'b1, 1'b0);
        chk("bubble_end", {dq_out, burst_last}, {8'hF8, 1'b1});

        // Reset mid-burst after beat 4
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        do_reset();
        step(1'b1, 8'h00, 1'b1, 1'b0);
        chk("post_rst_no_accept", dq_valid, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (i == 7) chk("post_rst_beat7", burst_last, 1'b0);
        end
        chk("post_rst_beat8", burst_last, 1'b1);

`ifdef DBI_AC_EN
        // AC decisions relative to the previously driven beat
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h00, 1'b1, 1'b1);
        chk("ac_first", {dq_out, dbi_out}, {8'hFF, 1'b1});
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        chk("ac_tie", {dq_out, dbi_out}, {8'hF0, 1'b0});
        step(1'b1, 8'h0F, 1'b1, 1'b0);
        chk("ac_invert", {dq_out, dbi_out}, {8'hF0, 1'b1});
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(9) < 7), 8'($urandom), ($urandom_range(7) != 0), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
